age_ordered_rs: RTL and testbench
=================================

AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

Interface
REQ-001 SHALL have parameter RS_WIDTH, default 3, log2 of entry count (DEPTH = 2**RS_WIDTH).
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB tag width.
REQ-003 SHALL have parameter RS_OP_WIDTH, default 4, ALU opcode width.
REQ-004 SHALL have parameter NUM_WB, default 2, count of external wakeup ports.
REQ-005 SHALL have port clockIn, input, 1, the single clock; all state rises on posedge.
REQ-006 SHALL have port resetIn, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port flushIn, input, 1, synchronous mispredict flush.
REQ-008 SHALL have ports addValid in 1, addReady out 1, addOp in RS_OP_WIDTH, addRobIndex in ROB_WIDTH, addVal1/addVal2 in 32, addHasDep1/addHasDep2 in 1, addConstrt1/addConstrt2 in ROB_WIDTH; together they are the dispatch handshake.
REQ-009 SHALL have ports wbValid in NUM_WB, wbRobIndex in NUM_WB*ROB_WIDTH, wbVal in NUM_WB*32; these are packed external wakeup buses, port p at slice p.
REQ-010 SHALL have ports resultValid out 1, resultReady in 1, resultRobIndex out ROB_WIDTH, resultVal out 32; together they are the result handshake.
REQ-011 SHALL have port occupancy, output, RS_WIDTH+1, count of valid entries.

Function
REQ-012 SHALL accept an entry on an edge where addValid && addReady && !flushIn; addReady = occupancy < DEPTH, registered state only, no same-cycle-free credit.
REQ-013 SHALL merge same-cycle wakeups into an accepted entry: an operand with a dependency whose tag matches a firing wakeup source stores that value with its dependency cleared. This applies to each operand independently.
REQ-014 Wakeup sources SHALL be wbValid[p], plus the internal exec-stage broadcast (REQ-018). On a tag match across several sources, the lowest p wins and the internal source is lowest priority.
REQ-015 Each edge, every valid entry with a pending operand whose tag matches a firing source SHALL capture the value and clear that dependency.
REQ-016 Select SHALL pick the oldest valid entry with both operands ready, where oldest means earliest accepted. Ordering SHALL use an age matrix or equivalent and be exact across wrap and any free pattern.
REQ-017 Select SHALL occur only when the exec stage is empty or advancing this edge. The selected entry moves to exec and is freed on the same edge.
REQ-018 Exec SHALL hold one operation and compute its result combinationally. It advances into the output register when !resultValid || resultReady. On that edge it fires the internal broadcast (tag robIdCal, value result).
REQ-019 Ops SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA (signed), 8 EQ, 9 NE, 10 LT (signed), 11 LTU. Shifts use v2[4:0]; compares return 32'd1 or 32'd0; opcodes 12-15 return 0.
REQ-020 Result registers SHALL hold stable while resultValid && !resultReady. resultValid clears only on a handshake with no exec advance.
REQ-021 Minimum latency: an entry accepted ready at edge k SHALL be selected at edge k+1 and show resultValid after edge k+2; its internal broadcast fires at edge k+2.
REQ-022 Back-pressure SHALL stall exec and select without losing or duplicating any operation or broadcast.
REQ-023 flushIn SHALL clear all entries, exec and resultValid at the edge. Adds and wakeups in that cycle are discarded.
REQ-024 occupancy SHALL equal the accepted minus selected entries, never exceeding DEPTH.

Reset
REQ-025 resetIn low SHALL immediately clear all entry valid bits, exec valid, resultValid, occupancy=0 and addReady=1, independent of clockIn, including mid-operation.
REQ-026 Data registers (values, tags, op) need no reset; outputs other than resultValid/addReady/occupancy are don't-care while resultValid=0.

Verification
REQ-027 Add ADD 5+7 rob3, no deps, resultReady=1 -> resultValid after edge k+2, resultRobIndex=3, resultVal=12.
REQ-028 Add A (rob1, dep1 on rob9) then B (rob2, ready); wbValid[1]=1 tag9 val=4 -> B issues first, A later with v1=4; neither result lost.
REQ-029 Add C=rob5 SUB 10-3, D=rob6 ADD dep1 on rob5, v2=1 -> D woken by internal broadcast, resultVal sequence 7 then 8.
REQ-030 Fill DEPTH entries -> addReady=0, occupancy=DEPTH. Hold resultReady=0 for 5 cycles -> no output change; release -> results emerge in age order.
REQ-031 Both operands pending on rob7 with wbValid[0] firing tag7 on the accept edge -> entry ready immediately, v1=v2=wbVal[0]; port-2 duplicate tag ignored.
REQ-032 flushIn or resetIn low mid-stream with 4 entries, exec busy -> occupancy=0, resultValid=0, addReady=1 next cycle; no stale result later.

Source files
------------

// File: rtl/age_ordered_rs_if.sv
// Dispatch, wakeup and result buses of the age-ordered reservation station.
// master drives dispatch/wakeups and consumes results; slave is the station.
interface age_ordered_rs_if #(
    parameter int RS_WIDTH    = 3,
    parameter int ROB_WIDTH   = 4,
    parameter int RS_OP_WIDTH = 4,
    parameter int NUM_WB      = 2
);
    logic                      addValid;
    logic                      addReady;
    logic [RS_OP_WIDTH-1:0]    addOp;
    logic [ROB_WIDTH-1:0]      addRobIndex;
    logic [31:0]               addVal1;
    logic [31:0]               addVal2;
    logic                      addHasDep1;
    logic                      addHasDep2;
    logic [ROB_WIDTH-1:0]      addConstrt1;
    logic [ROB_WIDTH-1:0]      addConstrt2;

    logic [NUM_WB-1:0]           wbValid;
    logic [NUM_WB*ROB_WIDTH-1:0] wbRobIndex;
    logic [NUM_WB*32-1:0]        wbVal;

    logic                      resultValid;
    logic                      resultReady;
    logic [ROB_WIDTH-1:0]      resultRobIndex;
    logic [31:0]               resultVal;

    logic [RS_WIDTH:0]         occupancy;

    modport master (
        output addValid, addOp, addRobIndex, addVal1, addVal2,
               addHasDep1, addHasDep2, addConstrt1, addConstrt2,
               wbValid, wbRobIndex, wbVal, resultReady,
        input  addReady, resultValid, resultRobIndex, resultVal, occupancy
    );

    modport slave (
        input  addValid, addOp, addRobIndex, addVal1, addVal2,
               addHasDep1, addHasDep2, addConstrt1, addConstrt2,
               wbValid, wbRobIndex, wbVal, resultReady,
        output addReady, resultValid, resultRobIndex, resultVal, occupancy
    );
endinterface

// File: rtl/age_ordered_rs.sv
// Reservation station with exact oldest-ready select via an age matrix,
// a one-deep exec stage, a registered result and an internal wakeup broadcast.
module age_ordered_rs #(
    parameter int RS_WIDTH    = 3,
    parameter int ROB_WIDTH   = 4,
    parameter int RS_OP_WIDTH = 4,
    parameter int NUM_WB      = 2
) (
    input  logic clockIn,
    input  logic resetIn,
    input  logic flushIn,
    age_ordered_rs_if.slave rs
);
    localparam int DEPTH = 2**RS_WIDTH;
    localparam logic [RS_WIDTH:0] DEPTH_CNT = (RS_WIDTH+1)'(DEPTH);

    function automatic logic [32:0] wake(
        input logic [ROB_WIDTH-1:0]        tag,
        input logic [NUM_WB-1:0]           wb_valid,
        input logic [NUM_WB*ROB_WIDTH-1:0] wb_tag,
        input logic [NUM_WB*32-1:0]        wb_val,
        input logic                        int_valid,
        input logic [ROB_WIDTH-1:0]        int_tag,
        input logic [31:0]                 int_val
    );
        logic [32:0] hit;
        hit = {int_valid && (int_tag == tag), int_val};
        // scan downward so the lowest matching port overrides everything else
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_tag[p*ROB_WIDTH +: ROB_WIDTH] == tag))
                hit = {1'b1, wb_val[p*32 +: 32]};
        end
        return hit;
    endfunction

    function automatic logic [31:0] alu(
        input logic [RS_OP_WIDTH-1:0] op,
        input logic [31:0]            a,
        input logic [31:0]            b
    );
        logic [31:0] r;
        r = '0;
        case (32'(op))
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a ^ b;
            3:       r = a | b;
            4:       r = a & b;
            5:       r = a << b[4:0];
            6:       r = a >> b[4:0];
            7:       r = 32'($signed(a) >>> b[4:0]);
            8:       r = {31'd0, a == b};
            9:       r = {31'd0, a != b};
            10:      r = {31'd0, $signed(a) < $signed(b)};
            11:      r = {31'd0, a < b};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DEPTH-1:0]       valid_reg;
    logic                   dep1_reg  [DEPTH];
    logic                   dep2_reg  [DEPTH];
    logic [DEPTH-1:0]       older_reg [DEPTH];
    logic [RS_OP_WIDTH-1:0] op_reg    [DEPTH];
    logic [ROB_WIDTH-1:0]   rob_reg   [DEPTH];
    logic [ROB_WIDTH-1:0]   tag1_reg  [DEPTH];
    logic [ROB_WIDTH-1:0]   tag2_reg  [DEPTH];
    logic [31:0]            val1_reg  [DEPTH];
    logic [31:0]            val2_reg  [DEPTH];
    logic [RS_WIDTH:0]      occ_reg;

    logic                   exec_valid_reg;
    logic [RS_OP_WIDTH-1:0] exec_op_reg;
    logic [ROB_WIDTH-1:0]   exec_rob_reg;
    logic [31:0]            exec_a_reg;
    logic [31:0]            exec_b_reg;
    logic                   result_valid_reg;
    logic [ROB_WIDTH-1:0]   result_rob_reg;
    logic [31:0]            result_val_reg;

    logic [31:0]            exec_result;
    logic                   exec_adv;
    logic                   add_fire;
    logic                   sel_fire;
    logic [DEPTH-1:0]       ready;
    logic [DEPTH-1:0]       oldest;
    logic [DEPTH-1:0]       alloc_onehot;
    logic [DEPTH-1:0]       sel_onehot;
    logic [RS_WIDTH-1:0]    alloc_idx;
    logic [RS_WIDTH-1:0]    sel_idx;
    logic [32:0]            add_wk1;
    logic [32:0]            add_wk2;
    logic [32:0]            ent_wk1 [DEPTH];
    logic [32:0]            ent_wk2 [DEPTH];

    assign rs.addReady       = occ_reg < DEPTH_CNT;
    assign rs.occupancy      = occ_reg;
    assign rs.resultValid    = result_valid_reg;
    assign rs.resultRobIndex = result_rob_reg;
    assign rs.resultVal      = result_val_reg;

    assign exec_result = alu(exec_op_reg, exec_a_reg, exec_b_reg);
    assign exec_adv    = exec_valid_reg && (!result_valid_reg || rs.resultReady);
    assign add_fire    = rs.addValid && rs.addReady && !flushIn;
    assign sel_fire    = (|oldest) && (!exec_valid_reg || exec_adv);
    assign sel_onehot  = sel_fire ? oldest : '0;
    assign alloc_onehot = add_fire ? (DEPTH'(1) << alloc_idx) : '0;

    assign add_wk1 = wake(rs.addConstrt1, rs.wbValid, rs.wbRobIndex, rs.wbVal,
                          exec_adv, exec_rob_reg, exec_result);
    assign add_wk2 = wake(rs.addConstrt2, rs.wbValid, rs.wbRobIndex, rs.wbVal,
                          exec_adv, exec_rob_reg, exec_result);

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_reg[i]) alloc_idx = i[RS_WIDTH-1:0];
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (oldest[i]) sel_idx = i[RS_WIDTH-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ready[gi]   = valid_reg[gi] && !dep1_reg[gi] && !dep2_reg[gi];
            // older_reg[gi] marks the entries accepted before entry gi
            assign oldest[gi]  = ready[gi] && !(|(ready & older_reg[gi]));
            assign ent_wk1[gi] = wake(tag1_reg[gi], rs.wbValid, rs.wbRobIndex, rs.wbVal,
                                      exec_adv, exec_rob_reg, exec_result);
            assign ent_wk2[gi] = wake(tag2_reg[gi], rs.wbValid, rs.wbRobIndex, rs.wbVal,
                                      exec_adv, exec_rob_reg, exec_result);

            always_ff @(posedge clockIn) begin
                if (alloc_onehot[gi]) begin
                    op_reg[gi]    <= rs.addOp;
                    rob_reg[gi]   <= rs.addRobIndex;
                    tag1_reg[gi]  <= rs.addConstrt1;
                    tag2_reg[gi]  <= rs.addConstrt2;
                    dep1_reg[gi]  <= rs.addHasDep1 && !add_wk1[32];
                    dep2_reg[gi]  <= rs.addHasDep2 && !add_wk2[32];
                    val1_reg[gi]  <= (rs.addHasDep1 && add_wk1[32]) ? add_wk1[31:0] : rs.addVal1;
                    val2_reg[gi]  <= (rs.addHasDep2 && add_wk2[32]) ? add_wk2[31:0] : rs.addVal2;
                    older_reg[gi] <= valid_reg;
                end else begin
                    if (dep1_reg[gi] && ent_wk1[gi][32]) begin
                        dep1_reg[gi] <= 1'b0;
                        val1_reg[gi] <= ent_wk1[gi][31:0];
                    end
                    if (dep2_reg[gi] && ent_wk2[gi][32]) begin
                        dep2_reg[gi] <= 1'b0;
                        val2_reg[gi] <= ent_wk2[gi][31:0];
                    end
                    // a slot being reused becomes younger than every survivor
                    older_reg[gi] <= older_reg[gi] & ~alloc_onehot;
                end
            end
        end
    endgenerate

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid_reg        <= '0;
            occ_reg          <= '0;
            exec_valid_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
        end else if (flushIn) begin
            valid_reg        <= '0;
            occ_reg          <= '0;
            exec_valid_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            valid_reg <= (valid_reg & ~sel_onehot) | alloc_onehot;
            occ_reg   <= occ_reg + (RS_WIDTH+1)'(add_fire) - (RS_WIDTH+1)'(sel_fire);
            if (sel_fire)
                exec_valid_reg <= 1'b1;
            else if (exec_adv)
                exec_valid_reg <= 1'b0;
            if (exec_adv)
                result_valid_reg <= 1'b1;
            else if (rs.resultReady)
                result_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clockIn) begin
        if (sel_fire) begin
            exec_op_reg  <= op_reg[sel_idx];
            exec_rob_reg <= rob_reg[sel_idx];
            exec_a_reg   <= val1_reg[sel_idx];
            exec_b_reg   <= val2_reg[sel_idx];
        end
        if (exec_adv) begin
            result_rob_reg <= exec_rob_reg;
            result_val_reg <= exec_result;
        end
    end
endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs: an age-ordered queue model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_age_ordered_rs;
    localparam int RS_WIDTH    = 3;
    localparam int ROB_WIDTH   = 4;
    localparam int RS_OP_WIDTH = 4;
    localparam int NUM_WB      = 2;
    localparam int DEPTH       = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    age_ordered_rs_if #(.RS_WIDTH(RS_WIDTH), .ROB_WIDTH(ROB_WIDTH),
                        .RS_OP_WIDTH(RS_OP_WIDTH), .NUM_WB(NUM_WB)) bus ();

    age_ordered_rs #(.RS_WIDTH(RS_WIDTH), .ROB_WIDTH(ROB_WIDTH),
                     .RS_OP_WIDTH(RS_OP_WIDTH), .NUM_WB(NUM_WB)) dut (
        .clockIn (clk),
        .resetIn (rst_n),
        .flushIn (flush),
        .rs      (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        bit          d1;
        bit          d2;
        logic [3:0]  t1;
        logic [3:0]  t2;
    } ent_t;

    ent_t        mq[$];      // waiting entries, oldest first
    bit          m_exv = 0;
    ent_t        m_ex;
    bit          m_rv = 0;
    logic [3:0]  m_rrob;
    logic [31:0] m_rval;
    logic [35:0] dut_log[$]; // {rob, val} of every result the DUT handed over

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'(sa >>> b[4:0]);
            4'd8:    return (a == b) ? 32'd1 : 32'd0;
            4'd9:    return (a != b) ? 32'd1 : 32'd0;
            4'd10:   return (sa < sb) ? 32'd1 : 32'd0;
            4'd11:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_wake(logic [3:0] tag, bit iv, logic [3:0] itag,
                                  logic [31:0] ival, output logic [31:0] v);
        for (int p = 0; p < NUM_WB; p++) begin
            if (bus.wbValid[p] && bus.wbRobIndex[p*4 +: 4] == tag) begin
                v = bus.wbVal[p*32 +: 32];
                return 1'b1;
            end
        end
        if (iv && itag == tag) begin
            v = ival;
            return 1'b1;
        end
        v = 32'd0;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit          adv;
        bit          acc;
        bit          hit;
        int          si;
        logic [3:0]  xrob;
        logic [31:0] xval;
        logic [31:0] w;
        ent_t        e;
        if (!rst_n || flush) begin
            mq.delete();
            m_exv = 0;
            m_rv  = 0;
            return;
        end
        adv  = m_exv && (!m_rv || bus.resultReady);
        xrob = m_ex.rob;
        xval = ref_alu(m_ex.op, m_ex.v1, m_ex.v2);
        acc  = bus.addValid && (mq.size() < DEPTH);
        si   = -1;
        if (!m_exv || adv)
            foreach (mq[i]) if (si < 0 && !mq[i].d1 && !mq[i].d2) si = i;
        if (adv) begin
            m_rv = 1; m_rrob = xrob; m_rval = xval;
        end else if (bus.resultReady) begin
            m_rv = 0;
        end
        if (si >= 0) begin
            m_ex = mq[si]; m_exv = 1; mq.delete(si);
        end else if (adv) begin
            m_exv = 0;
        end
        foreach (mq[i]) begin
            hit = m_wake(mq[i].t1, adv, xrob, xval, w);
            if (mq[i].d1 && hit) begin mq[i].d1 = 0; mq[i].v1 = w; end
            hit = m_wake(mq[i].t2, adv, xrob, xval, w);
            if (mq[i].d2 && hit) begin mq[i].d2 = 0; mq[i].v2 = w; end
        end
        if (acc) begin
            e.op = bus.addOp; e.rob = bus.addRobIndex;
            e.v1 = bus.addVal1; e.v2 = bus.addVal2;
            e.d1 = bus.addHasDep1; e.d2 = bus.addHasDep2;
            e.t1 = bus.addConstrt1; e.t2 = bus.addConstrt2;
            hit = m_wake(e.t1, adv, xrob, xval, w);
            if (e.d1 && hit) begin e.d1 = 0; e.v1 = w; end
            hit = m_wake(e.t2, adv, xrob, xval, w);
            if (e.d2 && hit) begin e.d2 = 0; e.v2 = w; end
            mq.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // per-cycle comparison against the model, away from the clock edge
    initial forever begin
        @(negedge clk);
        check("addReady", 32'(bus.addReady), (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        check("occupancy", 32'(bus.occupancy), mq.size());
        check("resultValid", 32'(bus.resultValid), 32'(m_rv));
        if (m_rv) begin
            check("resultRobIndex", 32'(bus.resultRobIndex), 32'(m_rrob));
            check("resultVal", bus.resultVal, m_rval);
        end
        if (rst_n && !flush && bus.resultValid && bus.resultReady)
            dut_log.push_back({bus.resultRobIndex, bus.resultVal});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic add(logic [3:0] op, logic [3:0] rob, logic [31:0] v1, logic [31:0] v2,
                       bit d1, logic [3:0] t1, bit d2, logic [3:0] t2);
        bus.addOp = op; bus.addRobIndex = rob;
        bus.addVal1 = v1; bus.addVal2 = v2;
        bus.addHasDep1 = d1; bus.addConstrt1 = t1;
        bus.addHasDep2 = d2; bus.addConstrt2 = t2;
        bus.addValid = 1'b1;
        step();
        bus.addValid = 1'b0;
    endtask

    task automatic wait_log(int n, int budget, string name);
        int c = 0;
        while (dut_log.size() < n && c < budget) begin
            step();
            c++;
        end
        check(name, (dut_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic expect_log(string name, int idx, logic [3:0] rob, logic [31:0] val);
        logic [35:0] t;
        if (idx < dut_log.size()) begin
            t = dut_log[idx];
            check({name, "_rob"}, 32'(t[35:32]), 32'(rob));
            check({name, "_val"}, t[31:0], val);
        end else begin
            check({name, "_present"}, dut_log.size(), idx + 1);
        end
    endtask

    // one result parked, one in exec, four entries waiting on a tag nobody sends
    task automatic build_busy();
        bus.resultReady = 1'b0;
        add(4'd0, 4'd1, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0);
        add(4'd0, 4'd2, 32'd2, 32'd2, 0, 4'd0, 0, 4'd0);
        for (int i = 3; i < 7; i++)
            add(4'd0, 4'(i), 32'd0, 32'd1, 1, 4'd15, 0, 4'd0);
        check("busy_occ", 32'(bus.occupancy), 32'd4);
        check("busy_rv", 32'(bus.resultValid), 32'd1);
        check("busy_rob", 32'(bus.resultRobIndex), 32'd1);
    endtask

    int base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addValid = 0; bus.addOp = '0; bus.addRobIndex = '0;
        bus.addVal1 = '0; bus.addVal2 = '0;
        bus.addHasDep1 = 0; bus.addHasDep2 = 0;
        bus.addConstrt1 = '0; bus.addConstrt2 = '0;
        bus.wbValid = '0; bus.wbRobIndex = '0; bus.wbVal = '0;
        bus.resultReady = 1'b1;

        step(2);
        check("rst_addReady", 32'(bus.addReady), 32'd1);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_rv", 32'(bus.resultValid), 32'd0);
        rst_n = 1'b1;
        step();

        // ADD 5+7 rob3: minimum latency
        base = dut_log.size();
        add(4'd0, 4'd3, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0);
        check("lat_k_occ", 32'(bus.occupancy), 32'd1);
        check("lat_k_rv", 32'(bus.resultValid), 32'd0);
        step();
        check("lat_k1_rv", 32'(bus.resultValid), 32'd0);
        check("lat_k1_occ", 32'(bus.occupancy), 32'd0);
        step();
        check("lat_k2_rv", 32'(bus.resultValid), 32'd1);
        check("lat_k2_rob", 32'(bus.resultRobIndex), 32'd3);
        check("lat_k2_val", bus.resultVal, 32'd12);
        step(2);
        expect_log("add57", base, 4'd3, 32'd12);

        // younger ready entry overtakes an older one waiting on port 1
        base = dut_log.size();
        add(4'd0, 4'd1, 32'd0, 32'd10, 1, 4'd9, 0, 4'd0);
        add(4'd0, 4'd2, 32'd2, 32'd3, 0, 4'd0, 0, 4'd0);
        bus.wbValid = 2'b10; bus.wbRobIndex = {4'd9, 4'd0}; bus.wbVal = {32'd4, 32'd0};
        step();
        bus.wbValid = '0;
        wait_log(base + 2, 20, "wb_drain");
        expect_log("wb_first", base, 4'd2, 32'd5);
        expect_log("wb_second", base + 1, 4'd1, 32'd14);

        // dependent woken by internal broadcast
        base = dut_log.size();
        add(4'd1, 4'd5, 32'd10, 32'd3, 0, 4'd0, 0, 4'd0);
        add(4'd0, 4'd6, 32'd0, 32'd1, 1, 4'd5, 0, 4'd0);
        wait_log(base + 2, 20, "int_drain");
        expect_log("int_sub", base, 4'd5, 32'd7);
        expect_log("int_add", base + 1, 4'd6, 32'd8);

        // both operands merged from port 0 on the accept edge; port 1 duplicate ignored
        base = dut_log.size();
        bus.wbValid = 2'b11; bus.wbRobIndex = {4'd7, 4'd7}; bus.wbVal = {32'd99, 32'd21};
        add(4'd0, 4'd4, 32'd0, 32'd0, 1, 4'd7, 1, 4'd7);
        bus.wbValid = '0;
        step(2);
        check("merge_rv", 32'(bus.resultValid), 32'd1);
        check("merge_rob", 32'(bus.resultRobIndex), 32'd4);
        check("merge_val", bus.resultVal, 32'd42);
        step(2);

        // every opcode on one operand pair
        base = dut_log.size();
        for (int op = 0; op < 16; op++)
            add(4'(op), 4'(op), 32'hF000_0005, 32'd3, 0, 4'd0, 0, 4'd0);
        wait_log(base + 16, 20, "ops_drain");
        expect_log("op_add", base + 0, 4'd0, 32'hF000_0008);
        expect_log("op_sub", base + 1, 4'd1, 32'hF000_0002);
        expect_log("op_sll", base + 5, 4'd5, 32'h8000_0028);
        expect_log("op_srl", base + 6, 4'd6, 32'h1E00_0000);
        expect_log("op_sra", base + 7, 4'd7, 32'hFE00_0000);
        expect_log("op_lt", base + 10, 4'd10, 32'd1);
        expect_log("op_ltu", base + 11, 4'd11, 32'd0);
        expect_log("op_12", base + 12, 4'd12, 32'd0);

        // fill under back-pressure, hold, then release in age order
        base = dut_log.size();
        bus.resultReady = 1'b0;
        for (int i = 0; i < 10; i++)
            add(4'd0, 4'(i), 32'(i), 32'd100, 0, 4'd0, 0, 4'd0);
        check("full_addReady", 32'(bus.addReady), 32'd0);
        check("full_occ", 32'(bus.occupancy), 32'd8);
        add(4'd0, 4'd10, 32'd10, 32'd100, 0, 4'd0, 0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_rob", 32'(bus.resultRobIndex), 32'd0);
            check("hold_val", bus.resultVal, 32'd100);
        end
        bus.resultReady = 1'b1;
        wait_log(base + 10, 40, "full_drain");
        step(4);
        check("full_count", dut_log.size(), base + 10);
        for (int i = 0; i < 10; i++)
            expect_log("full_order", base + i, 4'(i), 32'(i + 100));

        // flush mid-stream, with an add and a wakeup in the same cycle
        build_busy();
        flush = 1'b1;
        bus.wbValid = 2'b01; bus.wbRobIndex = {4'd0, 4'd15}; bus.wbVal = {32'd0, 32'd1};
        add(4'd0, 4'd7, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0);
        flush = 1'b0;
        bus.wbValid = '0;
        check("flush_occ", 32'(bus.occupancy), 32'd0);
        check("flush_rv", 32'(bus.resultValid), 32'd0);
        check("flush_addReady", 32'(bus.addReady), 32'd1);
        base = dut_log.size();
        bus.resultReady = 1'b1;
        step(6);
        check("flush_no_stale", dut_log.size(), base);

        // asynchronous reset mid-stream
        build_busy();
        rst_n = 1'b0;
        #1;
        check("arst_occ", 32'(bus.occupancy), 32'd0);
        check("arst_rv", 32'(bus.resultValid), 32'd0);
        check("arst_addReady", 32'(bus.addReady), 32'd1);
        step();
        rst_n = 1'b1;
        base = dut_log.size();
        bus.resultReady = 1'b1;
        step(6);
        check("arst_no_stale", dut_log.size(), base);

        // still functional after reset
        base = dut_log.size();
        add(4'd3, 4'd9, 32'h0F, 32'hF0, 0, 4'd0, 0, 4'd0);
        wait_log(base + 1, 10, "post_drain");
        expect_log("post_or", base, 4'd9, 32'hFF);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
